fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction buffer entries (legal 2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IFreq  output  1  fetch request to instruction memory.
REQ-006 IFaddr  output  32  word-aligned fetch address, valid while IFreq=1.
REQ-007 IFgnt  input  1  memory accepts request when IFreq&IFgnt.
REQ-008 IFrvalid  input  1  response valid, in order, >=1 cycle after its grant.
REQ-009 IFrdata  input  32  instruction word for oldest outstanding request.
REQ-010 IFvalid  output  1  buffered instruction available to decode.
REQ-011 IFinstr  output  32  instruction at buffer head.
REQ-012 IFpc  output  32  address of IFinstr.
REQ-013 IFready  input  1  decode consumes head when IFvalid&IFready.
REQ-014 IFredirect  input  1  branch/JAL/JALR taken; flush and refetch.
REQ-015 IFtarget  input  32  redirect address; bits [1:0] forced to 0.

Function
REQ-016 Internal fetch_pc SHALL drive IFaddr; it SHALL advance by 4 on each grant, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-017 IFreq SHALL be 1 only when occupancy + outstanding < FIFO_DEPTH and IFredirect=0; this reservation guarantees no response ever finds the buffer full.
REQ-018 IFaddr SHALL hold stable while IFreq=1 and IFgnt=0, except in a redirect cycle.
REQ-019 Outstanding counter SHALL +1 on grant, -1 on IFrvalid, both same cycle -> unchanged.
REQ-020 A non-discarded response SHALL push {IFpc=address of its request, IFrdata} into the buffer; IFvalid SHALL rise the cycle after IFrvalid (registered buffer).
REQ-021 IFvalid SHALL equal buffer non-empty; IFinstr/IFpc SHALL stay stable while IFvalid&!IFready.
REQ-022 Push and pop in the same cycle SHALL both take effect, occupancy unchanged.
REQ-023 On IFredirect: buffer SHALL flush (IFvalid=0 next cycle), fetch_pc <= {IFtarget[31:2],2'b00}, discard counter <= outstanding after this cycle's grant/response updates.
REQ-024 Responses arriving while discard counter > 0 SHALL be dropped and decrement it; the outstanding counter still decrements.
REQ-025 Redirect coinciding with a pop: the pop completes, flush still applies; redirect coinciding with a push: pushed entry is flushed.
REQ-026 New requests after redirect SHALL start the next cycle; min redirect-to-IFvalid latency = 3 cycles with IFgnt=1 and 1-cycle memory.
REQ-027 IFrvalid with outstanding=0 SHALL be ignored (no push, counters unchanged).

Reset
REQ-028 While reset=1: IFreq=0, IFvalid=0, IFaddr=RESET_PC, IFpc=0, IFinstr=32'h0000_0013, buffer empty, outstanding=0, discard=0.
REQ-029 Reset mid-operation SHALL abandon all in-flight requests; first IFreq=1 in the cycle after reset deasserts, address RESET_PC.

Structure
REQ-030 Shared package SHALL hold XLEN=32, NOP_INSTR=32'h0000_0013, DEFAULT_RESET_PC, and the buffer entry type {pc[31:0], instr[31:0]}.
REQ-031 Buffer SHALL be a sub-module fetch_fifo (synchronous FIFO: push, pop, flush, count, full/empty), parameterised by FIFO_DEPTH.
REQ-032 Request/reservation/discard logic SHALL live in fetch_unit; no combinational path IFrvalid -> IFvalid.

Verification
REQ-033 Reset release, IFgnt=1, 1-cycle memory, IFready=1 -> IFaddr 0x0,0x4,0x8...; IFpc/IFinstr match in order, 1 instr/cycle steady state.
REQ-034 IFready=0 for 10 cycles -> exactly FIFO_DEPTH entries buffered, IFreq=0, IFinstr/IFpc stable; release -> no loss or duplication.
REQ-035 Two requests outstanding, IFredirect with IFtarget=0x103 -> both responses dropped, next IFaddr=0x100, first IFpc after redirect=0x100.
REQ-036 IFgnt held 0 for 5 cycles -> IFaddr constant, no push; IFgnt=1 -> fetch resumes at same address.
REQ-037 fetch_pc=0xFFFF_FFFC granted -> next IFaddr=0x0000_0000.
REQ-038 reset asserted with one request outstanding, late IFrvalid after release -> ignored; first IFpc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Holds the word size, the NOP used as the idle instruction, and the buffer entry layout.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus bundle: memory request/response side plus the decode-facing instruction stream.
// The fetch unit sits on the master modport; memory and decode sit on the slave modport.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            IFreq;
  logic [XLEN-1:0] IFaddr;
  logic            IFgnt;
  logic            IFrvalid;
  logic [XLEN-1:0] IFrdata;
  logic            IFvalid;
  logic [XLEN-1:0] IFinstr;
  logic [XLEN-1:0] IFpc;
  logic            IFready;
  logic            IFredirect;
  logic [XLEN-1:0] IFtarget;

  modport master (
    output IFreq, IFaddr, IFvalid, IFinstr, IFpc,
    input  IFgnt, IFrvalid, IFrdata, IFready, IFredirect, IFtarget
  );

  modport slave (
    input  IFreq, IFaddr, IFvalid, IFinstr, IFpc,
    output IFgnt, IFrvalid, IFrdata, IFready, IFredirect, IFtarget
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs between memory and decode.
// Flush takes priority over a same-cycle push; a same-cycle pop simply leaves with the flush.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 push_data,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches, tracks in-flight requests, buffers responses
// for decode, and on a redirect flushes the buffer and drops responses still in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  fetch_unit_if.master   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]  fetch_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] discard;
  logic [CNT_W:0]   reserved;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             req;
  logic             grant;
  logic             rsp_accept;
  logic             rsp_keep;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  rsp_pc;

  // Reservation counts the slot freed by this cycle's pop, so a depth-2 buffer still streams
  // one instruction per cycle; every granted request is guaranteed a free slot on return.
  always_comb begin
    pop        = !reset && !fifo_empty && bus.IFready;
    reserved   = {1'b0, fifo_count} + {1'b0, outstanding} - {{CNT_W{1'b0}}, pop};
    req        = !reset && !bus.IFredirect && (reserved < (CNT_W+1)'(FIFO_DEPTH));
    grant      = req && bus.IFgnt;
    rsp_accept = !reset && bus.IFrvalid && (outstanding != '0);
    rsp_keep   = rsp_accept && (discard == '0);
    push       = rsp_keep && !fifo_full;
    outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(rsp_accept);
    // Kept requests are contiguous from the last redirect, so the oldest one sits
    // exactly 'outstanding' words behind the fetch pointer.
    rsp_pc     = fetch_pc - (XLEN'(outstanding) << 2);
    push_entry = '{pc: rsp_pc, instr: bus.IFrdata};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (bus.IFredirect) begin
        fetch_pc <= word_align(bus.IFtarget);
        discard  <= outstanding_next;
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_accept && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (bus.IFredirect),
    .push_data (push_entry),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    bus.IFreq   = req;
    bus.IFaddr  = reset ? RESET_PC : fetch_pc;
    bus.IFvalid = !reset && !fifo_empty;
    bus.IFinstr = (reset || fifo_empty) ? NOP_INSTR : fifo_head.instr;
    bus.IFpc    = (reset || fifo_empty) ? '0 : fifo_head.pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed phases with randomized memory/decode behaviour around fetch_unit, checked every
// cycle against a queue-based model of requests in flight and of the decode-side buffer.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if ifc();

  fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } mem_req_t;
  typedef struct { logic [31:0] addr; bit drop; } out_req_t;

  mem_req_t     memq[$];
  out_req_t     outq[$];
  fetch_entry_t bufq[$];

  logic [31:0] model_fetch;
  int cyc, n_compared, n_mismatched, pops;
  int gnt_pct, ready_pct, lat_min, lat_max, redir_pct, spur_pct;
  bit force_redirect;
  logic [31:0] force_target;
  bit watch_pop, watch_grant, watch_wrap, saw_wrap;
  logic [31:0] first_pop_pc, first_grant_addr;
  int lat_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance the model, step.
  task automatic applyStimulus(input bit rst);
    bit deliver, stale_pending, pop_exp, req_exp;
    out_req_t o;
    reset = rst;
    stale_pending = 1'b0;
    foreach (memq[i]) if (memq[i].stale) stale_pending = 1'b1;
    ifc.IFgnt   = !stale_pending && ($urandom_range(99) < gnt_pct);
    ifc.IFready = ($urandom_range(99) < ready_pct);
    if (force_redirect && !rst) begin
      ifc.IFredirect = 1'b1;
      ifc.IFtarget   = force_target;
      force_redirect = 1'b0;
    end else begin
      ifc.IFredirect = !rst && ($urandom_range(99) < redir_pct);
      ifc.IFtarget   = $urandom;
    end
    deliver = !rst && memq.size() > 0 && memq[0].due <= cyc;
    if (deliver) begin
      ifc.IFrvalid = 1'b1;
      ifc.IFrdata  = mem_word(memq[0].addr);
    end else if (!rst && memq.size() == 0 && $urandom_range(99) < spur_pct) begin
      ifc.IFrvalid = 1'b1;
      ifc.IFrdata  = $urandom;
    end else begin
      ifc.IFrvalid = 1'b0;
      ifc.IFrdata  = $urandom;
    end
    #1;
    if (rst) begin
      checkOutput("reset_req",   32'(ifc.IFreq),   32'd0);
      checkOutput("reset_valid", 32'(ifc.IFvalid), 32'd0);
      checkOutput("reset_addr",  ifc.IFaddr,       RST_PC);
      checkOutput("reset_pc",    ifc.IFpc,         32'h0);
      checkOutput("reset_instr", ifc.IFinstr,      32'h0000_0013);
      outq.delete();
      bufq.delete();
      model_fetch = RST_PC;
      foreach (memq[i]) memq[i].stale = 1'b1;
    end else begin
      pop_exp = bufq.size() > 0 && ifc.IFready;
      req_exp = !ifc.IFredirect && (bufq.size() - int'(pop_exp) + outq.size() < DEPTH);
      checkOutput("valid", 32'(ifc.IFvalid), 32'(bufq.size() > 0));
      if (bufq.size() > 0) begin
        checkOutput("head_pc",    ifc.IFpc,    bufq[0].pc);
        checkOutput("head_instr", ifc.IFinstr, bufq[0].instr);
      end
      checkOutput("req", 32'(ifc.IFreq), 32'(req_exp));
      if (req_exp) checkOutput("addr", ifc.IFaddr, model_fetch);
      if (pop_exp) begin
        if (watch_pop) begin
          first_pop_pc = ifc.IFpc;
          watch_pop = 1'b0;
        end
        void'(bufq.pop_front());
        pops++;
      end
      if (ifc.IFrvalid && outq.size() > 0) begin
        o = outq.pop_front();
        if (!o.drop) bufq.push_back('{pc: o.addr, instr: mem_word(o.addr)});
      end
      if (deliver) void'(memq.pop_front());
      if (req_exp && ifc.IFgnt) begin
        outq.push_back('{addr: model_fetch, drop: 1'b0});
        memq.push_back('{addr: ifc.IFaddr, due: cyc + int'($urandom_range(lat_max, lat_min)), stale: 1'b0});
        if (watch_grant) begin
          first_grant_addr = ifc.IFaddr;
          watch_grant = 1'b0;
        end
        if (watch_wrap && ifc.IFaddr == 32'h0) saw_wrap = 1'b1;
        model_fetch = model_fetch + 32'd4;
      end
      if (ifc.IFredirect) begin
        bufq.delete();
        foreach (outq[i]) outq[i].drop = 1'b1;
        model_fetch = {ifc.IFtarget[31:2], 2'b00};
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    ifc.IFgnt = 1'b0; ifc.IFrvalid = 1'b0; ifc.IFrdata = '0;
    ifc.IFready = 1'b0; ifc.IFredirect = 1'b0; ifc.IFtarget = '0;
    n_compared = 0; n_mismatched = 0; pops = 0; cyc = 0;
    force_redirect = 1'b0; force_target = '0;
    watch_pop = 1'b0; watch_grant = 1'b0; watch_wrap = 1'b0; saw_wrap = 1'b0;
    first_pop_pc = 32'hDEAD_BEEF; first_grant_addr = 32'hDEAD_BEEF;
    model_fetch = RST_PC;
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0; spur_pct = 0;
    @(negedge clk);

    $display("[TB] reset");
    repeat (3) applyStimulus(1'b1);

    $display("[TB] streaming from reset, 1-cycle memory");
    repeat (6) applyStimulus(1'b0);
    pops = 0;
    repeat (10) applyStimulus(1'b0);
    checkOutput("throughput", 32'(pops), 32'd10);

    $display("[TB] decode stall");
    ready_pct = 0;
    repeat (10) applyStimulus(1'b0);
    checkOutput("stall_req",   32'(ifc.IFreq),   32'd0);
    checkOutput("stall_valid", 32'(ifc.IFvalid), 32'd1);
    ready_pct = 100;
    repeat (8) applyStimulus(1'b0);

    $display("[TB] redirect with two requests in flight");
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 12; i++) begin
      if (outq.size() == 2) break;
      applyStimulus(1'b0);
    end
    checkOutput("two_inflight", 32'(outq.size()), 32'd2);
    force_redirect = 1'b1; force_target = 32'h0000_0103;
    watch_grant = 1'b1; watch_pop = 1'b1; first_pop_pc = 32'hDEAD_BEEF; first_grant_addr = 32'hDEAD_BEEF;
    repeat (14) applyStimulus(1'b0);
    checkOutput("redirect_addr", first_grant_addr, 32'h0000_0100);
    checkOutput("redirect_first_pc", first_pop_pc, 32'h0000_0100);

    $display("[TB] redirect latency");
    lat_min = 1; lat_max = 1;
    repeat (10) applyStimulus(1'b0);
    force_redirect = 1'b1; force_target = 32'h0000_0200;
    applyStimulus(1'b0);
    lat_cnt = 1;
    while (!ifc.IFvalid && lat_cnt < 8) begin
      applyStimulus(1'b0);
      lat_cnt++;
    end
    checkOutput("redirect_latency", 32'(lat_cnt), 32'd3);
    checkOutput("latency_pc", ifc.IFpc, 32'h0000_0200);

    $display("[TB] grant withheld");
    gnt_pct = 0;
    repeat (5) applyStimulus(1'b0);
    gnt_pct = 100;
    repeat (6) applyStimulus(1'b0);

    $display("[TB] address wrap");
    force_redirect = 1'b1; force_target = 32'hFFFF_FFF8;
    watch_wrap = 1'b1; saw_wrap = 1'b0;
    repeat (8) applyStimulus(1'b0);
    watch_wrap = 1'b0;
    checkOutput("wrap_to_zero", 32'(saw_wrap), 32'd1);

    $display("[TB] reset with request in flight");
    lat_min = 4; lat_max = 4;
    for (int i = 0; i < 8; i++) begin
      if (outq.size() >= 1) break;
      applyStimulus(1'b0);
    end
    repeat (2) applyStimulus(1'b1);
    lat_min = 1; lat_max = 1;
    watch_pop = 1'b1; first_pop_pc = 32'hDEAD_BEEF;
    repeat (12) applyStimulus(1'b0);
    checkOutput("post_reset_pc", first_pop_pc, RST_PC);

    $display("[TB] randomized traffic");
    gnt_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 4; redir_pct = 5; spur_pct = 10;
    repeat (400) applyStimulus(1'b0);

    gnt_pct = 0; ready_pct = 100; redir_pct = 0; spur_pct = 0;
    repeat (20) applyStimulus(1'b0);
    checkOutput("drain_empty", 32'(ifc.IFvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
